matrix_mac_engine: RTL
======================

MATRIX_MAC_ENGINE -- requirements
Module: matrix_mac_engine

Interface
REQ-001 SHALL have parameter N, default 4, meaning matrix dimension (N x N), legal range 2..8.
REQ-002 SHALL have parameter W, default 32, meaning element width in bits, signed two's complement, legal range 8..32.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port A_stb, input, 1 bit: operand A valid.
REQ-006 SHALL have port B_stb, input, 1 bit: operand B valid.
REQ-007 SHALL have port A, input, N*N*W bits: matrix A, row-major; element (r,c) at bits [((r*N+c)*W)+:W].
REQ-008 SHALL have port B, input, N*N*W bits: matrix B, same packing as A.
REQ-009 SHALL have port C, input, N*N*W bits: addend matrix, same packing as A.
REQ-010 SHALL have port mode, input, 2 bits: bit0 = accumulate (add C), bit1 = saturate (else wrap).
REQ-011 SHALL have port result_ack, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port result_ready, output, 1 bit: result valid.
REQ-013 SHALL have port result, output, N*N*W bits: result matrix, same packing as A.
REQ-014 SHALL have port busy, output, 1 bit: operation in progress or result pending.
REQ-015 SHALL have port overflow, output, 1 bit: sticky per operation; any element exceeded the signed W range.

Function
REQ-016 SHALL implement the FSM states S_IDLE, S_MAC and S_DONE.
REQ-017 In S_IDLE, an edge sampling A_stb=1 and B_stb=1 SHALL capture A, B, C and mode into internal registers, set busy=1, clear overflow, zero the accumulator and indices i, j, k, and go to S_MAC.
REQ-018 A_stb and B_stb SHALL be ignored unless both are high in S_IDLE; a lone strobe SHALL capture nothing.
REQ-019 Each S_MAC cycle SHALL perform exactly one MAC, acc += A[i][k]*B[k][j], using a full 2W-bit signed product.
REQ-020 The accumulator SHALL be 2W+clog2(N)+2 bits wide so that no intermediate overflow is possible.
REQ-021 When k=N-1, the exact element value SHALL be acc + product + (mode[0] ? sign-extended C[i][j] : 0).
REQ-022 That exact value SHALL be written to result element (i,j) on the same edge, after the width rule is applied.
REQ-023 After each element write, the accumulator SHALL be cleared, k SHALL reset to 0, and the indices SHALL advance j first, then i.
REQ-024 Width rule: mode[1]=0 SHALL keep the low W bits (wrap).
REQ-025 Width rule: mode[1]=1 SHALL clamp to 2^(W-1)-1 or -2^(W-1).
REQ-026 overflow SHALL be set whenever the exact value lies outside the signed W range, regardless of mode.
REQ-027 The edge performing the final MAC (i=j=k=N-1) SHALL set result_ready=1 and go to S_DONE.
REQ-028 Latency SHALL be N^3 edges: capture at edge E0 gives result_ready=1 after edge E0+N^3.
REQ-029 In S_DONE, result, result_ready, overflow and busy SHALL hold stable until result_ready=1 and result_ack=1 are sampled together.
REQ-030 On the ack edge, result_ready and busy SHALL go to 0 and the FSM SHALL return to S_IDLE.
REQ-031 result and overflow SHALL keep their values until the next capture.
REQ-032 Strobes sampled on the ack edge SHALL NOT be captured; the earliest new capture is the following edge.
REQ-033 result_ack while result_ready=0 SHALL be ignored.
REQ-034 Strobes while busy=1 SHALL be ignored; captured operands SHALL NOT change mid-operation.
REQ-035 result SHALL change only during S_MAC element writes.

Reset
REQ-036 reset=1 sampled on an edge SHALL force S_IDLE and result_ready=0, busy=0, overflow=0, result=0, and SHALL clear the indices and accumulator.
REQ-037 reset SHALL take priority over strobes and result_ack on the same edge.
REQ-038 reset during S_MAC or S_DONE SHALL abort the operation with no result_ready pulse.

Verification (N=2, W=8)
REQ-039 Scenario: A=I, B=[[1,2],[3,4]], mode=00 -> result [[1,2],[3,4]], result_ready exactly 8 edges after capture, overflow=0.
REQ-040 Scenario: A=[[1,2],[3,4]], B=[[5,6],[7,8]], C all 1, mode=01 -> result [[20,23],[44,51]], overflow=0.
REQ-041 Scenario: A,B all 127, mode=10 -> all elements 127, overflow=1; same operands with mode=00 -> all elements 2 (32258 mod 256), overflow=1.
REQ-042 Scenario: A all -128, B all 127, mode=10 -> all elements -128 (0x80), overflow=1.
REQ-043 Scenario: hold result_ack=0 for 5 cycles in S_DONE while pulsing both strobes with new data -> result and result_ready stable, no capture; ack -> result_ready=0, busy=0 after that edge.
REQ-044 Scenario: reset at the 3rd S_MAC cycle -> next edge all outputs 0, no result_ready; a following operation (scenario REQ-040) completes correctly; A_stb alone -> busy stays 0.

Source files
------------

// File: rtl/matrix_mac_engine_if.sv
// matrix_mac_engine_if: operand/result bus of the matrix multiply-accumulate engine
interface matrix_mac_engine_if #(parameter int N = 4, parameter int W = 32);
  logic A_stb;
  logic B_stb;
  logic [N*N*W-1:0] A;
  logic [N*N*W-1:0] B;
  logic [N*N*W-1:0] C;
  logic [1:0] mode;
  logic result_ack;
  logic result_ready;
  logic [N*N*W-1:0] result;
  logic busy;
  logic overflow;
  modport master (
    output A_stb, B_stb, A, B, C, mode, result_ack,
    input result_ready, result, busy, overflow
  );
  modport slave (
    input A_stb, B_stb, A, B, C, mode, result_ack,
    output result_ready, result, busy, overflow
  );
endinterface

// File: rtl/matrix_mac_engine.sv
// matrix_mac_engine: sequential N x N signed matrix multiply (+C), one MAC per cycle, wrap or saturate
module matrix_mac_engine #(
  parameter int N = 4,
  parameter int W = 32
) (
  input logic clk,
  input logic reset,
  matrix_mac_engine_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int AW = 2*W + $clog2(N) + 2;
  localparam int MW = N*N*W;
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;
  state_t r_state, w_next;
  logic [MW-1:0] r_a, r_b, r_c, r_result;
  logic [1:0] r_mode;
  logic [IW-1:0] r_i, r_j, r_k;
  logic signed [AW-1:0] r_acc, w_exact;
  logic r_ready, r_busy, r_ovf;
  logic signed [W-1:0] w_aik, w_bkj, w_cij, w_elem;
  logic signed [2*W-1:0] w_prod;
  logic w_start, w_last_i, w_last_j, w_last_k, w_last, w_ovf;
  assign w_aik = r_a[(int'(r_i)*N + int'(r_k))*W +: W];
  assign w_bkj = r_b[(int'(r_k)*N + int'(r_j))*W +: W];
  assign w_cij = r_c[(int'(r_i)*N + int'(r_j))*W +: W];
  assign w_prod = w_aik * w_bkj;
  assign w_exact = r_acc + AW'(w_prod) + (r_mode[0] ? AW'(w_cij) : AW'(0));
  // in range iff every bit from the W-1 sign position upward agrees
  assign w_ovf = !((&w_exact[AW-1:W-1]) || !(|w_exact[AW-1:W-1]));
  assign w_elem = (r_mode[1] && w_ovf)
    ? (w_exact[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
    : w_exact[W-1:0];
  assign w_start = (r_state == S_IDLE) && bus.A_stb && bus.B_stb;
  assign w_last_i = r_i == IW'(N-1);
  assign w_last_j = r_j == IW'(N-1);
  assign w_last_k = r_k == IW'(N-1);
  assign w_last = w_last_i && w_last_j && w_last_k;
  always_comb begin
    w_next = r_state;
    w_next = w_start ? S_MAC
           : (r_state == S_MAC && w_last) ? S_DONE
           : (r_state == S_DONE && bus.result_ack) ? S_IDLE
           : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
      r_mode <= '0;
      r_result <= '0;
      r_acc <= '0;
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
      r_ready <= 1'b0;
      r_busy <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_start) begin
      r_a <= bus.A;
      r_b <= bus.B;
      r_c <= bus.C;
      r_mode <= bus.mode;
      r_acc <= '0;
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
      r_busy <= 1'b1;
      r_ovf <= 1'b0;
    end else if (r_state == S_MAC) begin
      if (w_last_k) begin
        r_result[(int'(r_i)*N + int'(r_j))*W +: W] <= w_elem;
        r_acc <= '0;
        r_k <= '0;
        r_j <= w_last_j ? '0 : r_j + 1'b1;
        if (w_last_j) r_i <= w_last_i ? '0 : r_i + 1'b1;
        if (w_ovf) r_ovf <= 1'b1;
        if (w_last) r_ready <= 1'b1;
      end else begin
        r_acc <= r_acc + AW'(w_prod);
        r_k <= r_k + 1'b1;
      end
    end else if (r_state == S_DONE && bus.result_ack) begin
      r_ready <= 1'b0;
      r_busy <= 1'b0;
    end
  end
  assign bus.result_ready = r_ready;
  assign bus.result = r_result;
  assign bus.busy = r_busy;
  assign bus.overflow = r_ovf;
endmodule
